// File: rtl/serial_bus_pkg.sv
// Frame layout, transfer direction and slave state encoding shared by every
// agent on the serial bus (slaves, masters and the interconnect).
package serial_bus_pkg;

    localparam logic [2:0] START = 3'b111;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } rw_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DECODE,
        ST_FETCH,
        ST_RSEND,
        ST_RACK,
        ST_WRITE
    } state_e;

    // Field positions counted from the LSB of a frame without a parity bit.
    function automatic int addr_lsb(input int addr_w);
        return addr_w - addr_w;
    endfunction

    function automatic int burst_bit(input int addr_w);
        return addr_w;
    endfunction

    function automatic int rw_bit(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int id_lsb(input int addr_w);
        return addr_w + 2;
    endfunction

    function automatic int start_lsb(input int id_w, input int addr_w);
        return addr_w + 2 + id_w;
    endfunction

    function automatic int frame_bits(input int id_w, input int addr_w);
        return start_lsb(id_w, addr_w) + 3;
    endfunction

endpackage

// File: rtl/slave_ram.sv
// Single-port word memory: synchronous write, registered read.
module slave_ram #(
    parameter int ADDR_DEPTH = 2000,
    parameter int DATA_WIDTH = 32,
    localparam int AW = $clog2(ADDR_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            q <= mem[addr];
    end

endmodule

// File: rtl/serial_slave_mlane.sv
// Multi-lane serial bus slave with configurable read latency, wrapping bursts
// and replay of unacknowledged reads. Define SERIAL_PARITY_EN for frame parity.
module serial_slave_mlane
    import serial_bus_pkg::*;
#(
    parameter int ADDR_DEPTH = 2000,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1,
    parameter int SLAVES     = 3,
    parameter int S_ID_WIDTH = $clog2(SLAVES + 1),
    parameter int SLAVEID    = 1,
    parameter int DELAY      = 0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             control,
    input  logic [LANES-1:0] wD,
    input  logic             valid,
    input  logic             last,
    output logic [LANES-1:0] rD,
    output logic             ready,
    output logic             err
);

    localparam int AW    = $clog2(ADDR_DEPTH);
    localparam int BEATS = DATA_WIDTH / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
`ifdef SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL    = frame_bits(S_ID_WIDTH, AW) + PAR;
    localparam int CW    = $clog2(FL + 1);
    localparam int A_LSB = PAR + addr_lsb(AW);
    localparam int B_POS = PAR + burst_bit(AW);
    localparam int R_POS = PAR + rw_bit(AW);
    localparam int I_LSB = PAR + id_lsb(AW);
    localparam int S_LSB = PAR + start_lsb(S_ID_WIDTH, AW);

    state_e                  state;
    logic [FL-1:0]           frame;
    logic [CW-1:0]           bit_cnt;
    logic [AW-1:0]           addr, next_addr, wr_addr, held_addr, ram_addr;
    logic                    burst, held_vld, rd_src, wr_pend, ram_re;
    logic [BW-1:0]           beat;
    logic [3:0]              wait_cnt;
    logic [DATA_WIDTH-1:0]   tx_shift, wr_shift, held_word, ram_q, src_word;

    logic [AW-1:0]           f_addr;
    logic                    f_burst;
    rw_e                     f_rw;
    logic [S_ID_WIDTH-1:0]   f_id;
    logic [2:0]              f_start;
    logic                    hit, addr_bad, parity_bad;

    assign f_addr   = frame[A_LSB +: AW];
    assign f_burst  = frame[B_POS];
    assign f_rw     = rw_e'(frame[R_POS]);
    assign f_id     = frame[I_LSB +: S_ID_WIDTH];
    assign f_start  = frame[S_LSB +: 3];
    assign hit      = (f_start == START) && (f_id == S_ID_WIDTH'(SLAVEID));
    assign addr_bad = 32'(f_addr) >= 32'(ADDR_DEPTH);
`ifdef SERIAL_PARITY_EN
    assign parity_bad = ^frame;
`else
    assign parity_bad = 1'b0;
`endif

    assign next_addr = (addr == AW'(ADDR_DEPTH - 1)) ? '0 : addr + AW'(1);
    assign src_word  = rd_src ? ram_q : held_word;
    assign ram_re    = (state == ST_FETCH) && (wait_cnt == 4'(DELAY));
    assign ram_addr  = wr_pend ? wr_addr : addr;

    slave_ram #(
        .ADDR_DEPTH(ADDR_DEPTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_pend),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(wr_shift),
        .q    (ram_q)
    );

    // Beat 0 is taken straight from the word source because the RAM result
    // only lands on the edge that enters RSEND.
    always_comb begin
        ready = 1'b0;
        rD    = '0;
        err   = 1'b0;
        case (state)
            ST_IDLE:    ready = 1'b1;
            ST_CAPTURE: ready = (bit_cnt != CW'(FL - 1));
            ST_DECODE: begin
                err   = hit && (parity_bad || addr_bad);
                ready = hit && !parity_bad && !addr_bad && (f_rw == WRITE);
            end
            ST_RSEND: begin
                ready = 1'b1;
                rD    = (beat == '0) ? src_word[DATA_WIDTH-1 -: LANES]
                                     : tx_shift[DATA_WIDTH-1 -: LANES];
            end
            ST_WRITE:   ready = 1'b1;
            default:    ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ST_IDLE;
            frame     <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            burst     <= 1'b0;
            beat      <= '0;
            wait_cnt  <= '0;
            rd_src    <= 1'b0;
            tx_shift  <= '0;
            wr_shift  <= '0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            held_vld  <= 1'b0;
            held_addr <= '0;
            held_word <= '0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend && (wr_addr == held_addr))
                held_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (control) begin
                        frame   <= {frame[FL-2:0], control};
                        bit_cnt <= CW'(1);
                        state   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    frame   <= {frame[FL-2:0], control};
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == CW'(FL - 1))
                        state <= ST_DECODE;
                end
                ST_DECODE: begin
                    addr     <= f_addr;
                    burst    <= f_burst;
                    beat     <= '0;
                    wait_cnt <= '0;
                    if (!hit || parity_bad || addr_bad)
                        state <= ST_IDLE;
                    else if (f_rw == WRITE)
                        state <= ST_WRITE;
                    else if (held_vld && (f_addr == held_addr)) begin
                        rd_src <= 1'b0;
                        state  <= ST_RSEND;
                    end else
                        state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (wait_cnt == 4'(DELAY)) begin
                        rd_src <= 1'b1;
                        beat   <= '0;
                        state  <= ST_RSEND;
                    end else
                        wait_cnt <= wait_cnt + 4'd1;
                end
                ST_RSEND: begin
                    tx_shift <= ((beat == '0) ? src_word : tx_shift) << LANES;
                    if (beat == BW'(BEATS - 1))
                        state <= ST_RACK;
                    else
                        beat <= beat + BW'(1);
                end
                ST_RACK: begin
                    if (valid && (!burst || last)) begin
                        held_vld <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (valid) begin
                        addr     <= next_addr;
                        wait_cnt <= '0;
                        state    <= ST_FETCH;
                    end else begin
                        held_word <= src_word;
                        held_addr <= addr;
                        held_vld  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (valid) begin
                        wr_shift <= (wr_shift << LANES) | DATA_WIDTH'(wD);
                        if (beat == BW'(BEATS - 1)) begin
                            beat    <= '0;
                            wr_pend <= 1'b1;
                            wr_addr <= addr;
                            if (!burst || last)
                                state <= ST_IDLE;
                            else
                                addr <= next_addr;
                        end else
                            beat <= beat + BW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_slave_mlane.sv
// Randomised scoreboard bench for serial_slave_mlane (LANES=4, DELAY=2) with a
// word-level memory model; honours SERIAL_PARITY_EN when building frames.
`timescale 1ns/1ps
module tb_serial_slave_mlane;

    localparam int AD    = 2000;
    localparam int DW    = 32;
    localparam int LN    = 4;
    localparam int NSL   = 3;
    localparam int IDW   = $clog2(NSL + 1);
    localparam int AW    = $clog2(AD);
    localparam int DL    = 2;
    localparam int BEATS = DW / LN;
    localparam int FL0   = 5 + IDW + AW;
`ifdef SERIAL_PARITY_EN
    localparam int FL = FL0 + 1;
`else
    localparam int FL = FL0;
`endif

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          control = 1'b0;
    logic          valid = 1'b0;
    logic          last = 1'b0;
    logic [LN-1:0] wD = '0;
    logic [LN-1:0] rD;
    logic          ready;
    logic          err;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int exp_err_cyc = -1;

    typedef struct {
        logic [DW-1:0] data;
        int            ref_cyc;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    bit            mon_busy = 1'b0;
    logic [DW-1:0] mdl_mem [int];
    bit            mdl_held_vld = 1'b0;
    int            mdl_held_addr = 0;

    serial_slave_mlane #(
        .ADDR_DEPTH(AD),
        .DATA_WIDTH(DW),
        .LANES     (LN),
        .SLAVES    (NSL),
        .SLAVEID   (1),
        .DELAY     (DL)
    ) dut (
        .clk    (clk),
        .rstN   (rstN),
        .control(control),
        .wD     (wD),
        .valid  (valid),
        .last   (last),
        .rD     (rD),
        .ready  (ready),
        .err    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wrapInc(input int a);
        return (a + 1) % AD;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifts a complete frame out MSB first; returns the DECODE cycle.
    task automatic applyStimulus(input int id, input logic rw, input logic bst, input int a, output int dec);
        logic [FL0-1:0] base;
        logic [FL-1:0]  bits;
        base = {3'b111, IDW'(id), rw, bst, AW'(a)};
`ifdef SERIAL_PARITY_EN
        bits = {base, ^base};
`else
        bits = base;
`endif
        for (int i = FL - 1; i >= 0; i--) begin
            control = bits[i];
            tick();
        end
        control = 1'b0;
        dec = cyc;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: scoreboard still holds %0d entries at cycle %0d", sb.size(), cyc);
        end
        repeat (2) tick();
    endtask

    task automatic doWrite(input int a, input int n, input logic bst, input logic [DW-1:0] first);
        int            dec;
        int            ma;
        logic [DW-1:0] word;
        logic [DW-1:0] tmp;
        applyStimulus(1, 1'b1, bst, a, dec);
        checkOutput("ready_wr_decode", 32'(ready), 32'd1);
        tick();
        ma = a;
        for (int w = 0; w < n; w++) begin
            word = (w == 0) ? first : $urandom;
            for (int b = 0; b < BEATS; b++) begin
                if ($urandom_range(0, 2) == 0) begin
                    valid = 1'b0;
                    checkOutput("ready_wr_gap", 32'(ready), 32'd1);
                    tick();
                end
                tmp   = word << (b * LN);
                wD    = tmp[DW-1 -: LN];
                valid = 1'b1;
                last  = (w == n - 1) && (b == BEATS - 1);
                checkOutput("ready_wr_beat", 32'(ready), 32'd1);
                tick();
            end
            mdl_mem[ma] = word;
            if (mdl_held_vld && mdl_held_addr == ma)
                mdl_held_vld = 1'b0;
            ma = wrapInc(ma);
        end
        valid = 1'b0;
        last  = 1'b0;
        checkOutput("ready_after_wr", 32'(ready), 32'd1);
        repeat (2) tick();
    endtask

    task automatic doRead(input int a, input int n, input logic bst, input bit ack);
        int   dec;
        int   lat;
        int   refc;
        int   ma;
        int   last_a;
        int   racks[$];
        exp_t e;
        applyStimulus(1, 1'b0, bst, a, dec);
        lat  = (mdl_held_vld && mdl_held_addr == a) ? 1 : DL + 2;
        refc = dec;
        ma   = a;
        last_a = a;
        for (int k = 0; k < n; k++) begin
            e.data    = mdl_mem[ma];
            e.ref_cyc = refc;
            e.lat     = lat;
            sb.push_back(e);
            racks.push_back(refc + lat + BEATS);
            refc   = refc + lat + BEATS;
            lat    = DL + 2;
            last_a = ma;
            ma     = wrapInc(ma);
        end
        for (int k = 0; k < n; k++) begin
            while (cyc < racks[k]) tick();
            valid = (k < n - 1) || ack;
            last  = (k == n - 1);
            tick();
            valid = 1'b0;
            last  = 1'b0;
        end
        if (ack)
            mdl_held_vld = 1'b0;
        else begin
            mdl_held_vld  = 1'b1;
            mdl_held_addr = last_a;
        end
        waitIdle();
    endtask

    // Monitor: pops one expected word, measures latency to the first beat and collects the beats.
    initial begin : monitor
        exp_t          e;
        logic [DW-1:0] got;
        int            n;
        forever begin
            while (sb.size() == 0) @(negedge clk);
            mon_busy = 1'b1;
            e = sb.pop_front();
            do @(negedge clk); while (cyc < e.ref_cyc + 1);
            n = 0;
            while (!ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!ready) begin
                checks++;
                errors++;
                $display("[TB] FAIL read_timeout: no data beat within 40 cycles of cycle %0d", e.ref_cyc);
            end else begin
                checkOutput("read_latency", 32'(cyc - e.ref_cyc), 32'(e.lat));
                got = '0;
                for (int b = 0; b < BEATS; b++) begin
                    got = {got[DW-LN-1:0], rD};
                    if (b < BEATS - 1) @(negedge clk);
                end
                checkOutput("read_data", got, e.data);
            end
            mon_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (err || cyc == exp_err_cyc)
            checkOutput("err_pulse", 32'(err), 32'(cyc == exp_err_cyc));
    end

    initial begin : stim
        int dec;
        int a;
        int n;
        repeat (3) tick();
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_rD", 32'(rD), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        rstN = 1'b1;
        tick();

        doWrite(5, 1, 1'b0, 32'hDEADBEEF);
        doRead(5, 1, 1'b0, 1'b1);

        doWrite(7, 1, 1'b0, $urandom);
        doRead(7, 1, 1'b0, 1'b0);
        doRead(7, 1, 1'b0, 1'b1);

        doWrite(AD - 1, 3, 1'b1, $urandom);
        doRead(AD - 1, 1, 1'b0, 1'b1);
        doRead(0, 1, 1'b0, 1'b1);
        doRead(1, 1, 1'b0, 1'b1);
        doRead(AD - 1, 2, 1'b1, 1'b1);

        applyStimulus(2, 1'b0, 1'b0, 5, dec);
        tick();
        checkOutput("foreign_ready", 32'(ready), 32'd1);
        repeat (6) begin
            tick();
            checkOutput("foreign_silent", 32'(rD), 32'd0);
        end

        exp_err_cyc = cyc + FL;
        applyStimulus(1, 1'b0, 1'b0, 2047, dec);
        tick();
        checkOutput("err_then_idle", 32'(ready), 32'd1);
        repeat (3) tick();

        doWrite(9, 1, 1'b0, 32'h13572468);
        doRead(9, 1, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0, 9, dec);
        while (cyc < dec + 3) tick();
        checkOutput("replay_beat2", 32'(rD), 32'h5);
        #1 rstN = 1'b0;
        #1;
        checkOutput("async_rst_rD", 32'(rD), 32'd0);
        checkOutput("async_rst_ready", 32'(ready), 32'd1);
        tick();
        rstN = 1'b1;
        mdl_held_vld = 1'b0;
        tick();
        doRead(9, 1, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9) : AD - 1 - $urandom_range(0, 2);
            if (!mdl_mem.exists(a) || $urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 2);
                doWrite(a, n, n > 1, $urandom);
            end else
                doRead(a, 1, 1'b0, $urandom_range(0, 1) == 1);
        end

        waitIdle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
